// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM encoding, requester ids and sizing helpers for the memory port arbiter.
package mem_port_arbiter_pkg;
   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 32;
   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;
   typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DRAIN, WR} state_t;
   function automatic int beat_w(input int line_words);
      return $clog2(line_words);
   endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes, shared read return path and the single memory port.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int LINE_WORDS = 4
);
   localparam int BW = beat_w(LINE_WORDS);
   logic I_REQ, D_REQ, I_WE, D_WE;
   logic [ADDR_W-1:0] I_ADDR, D_ADDR;
   logic [DATA_W-1:0] I_WDATA, D_WDATA;
   logic [3:0] I_BE, D_BE;
   logic I_GNT, D_GNT, I_RVALID, D_RVALID, I_DONE, D_DONE;
   logic [DATA_W-1:0] RDATA;
   logic [BW-1:0] RBEAT;
   logic D_MEM_CSN, D_MEM_WEN;
   logic [3:0] D_MEM_BE;
   logic [ADDR_W-1:0] D_MEM_ADDR;
   logic [DATA_W-1:0] D_MEM_DOUT, D_MEM_DI;
   modport slave (
      input  I_REQ, D_REQ, I_WE, D_WE, I_ADDR, D_ADDR, I_WDATA, D_WDATA, I_BE, D_BE, D_MEM_DI,
      output I_GNT, D_GNT, I_RVALID, D_RVALID, I_DONE, D_DONE, RDATA, RBEAT,
             D_MEM_CSN, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DOUT
   );
   modport master (
      output I_REQ, D_REQ, I_WE, D_WE, I_ADDR, D_ADDR, I_WDATA, D_WDATA, I_BE, D_BE, D_MEM_DI,
      input  I_GNT, D_GNT, I_RVALID, D_RVALID, I_DONE, D_DONE, RDATA, RBEAT,
             D_MEM_CSN, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DOUT
   );
endinterface

// File: rtl/mem_port_arbiter_pipe.sv
// mem_lat_pipe: LAT-deep valid/payload delay line tracking read addresses in flight; a wire when LAT=0.
module mem_lat_pipe #(
   parameter int LAT = 0,
   parameter int W   = 1
) (
   input  logic         CLK,
   input  logic         RSTn,
   input  logic         in_v,
   input  logic [W-1:0] in_d,
   output logic         out_v,
   output logic [W-1:0] out_d
);
   localparam int D = LAT > 0 ? LAT : 1;
   logic [D-1:0] v_q;
   logic [W-1:0] d_q [D];
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         v_q <= '0;
         for (int i = 0; i < D; i++) d_q[i] <= '0;
      end else begin
         v_q[0] <= in_v;
         d_q[0] <= in_d;
         for (int i = 1; i < D; i++) begin
            v_q[i] <= v_q[i-1];
            d_q[i] <= d_q[i-1];
         end
      end
   end
   assign out_v = LAT > 0 ? v_q[D-1] : in_v;
   assign out_d = LAT > 0 ? d_q[D-1] : in_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin I/D arbiter for one memory port; burst line refills and single-word stores.
// Define MEM_ARB_CRIT_WORD_FIRST_EN to start read bursts at the requested word and wrap.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int LINE_WORDS = 4,
   parameter int MEM_LAT    = 0
) (
   input logic CLK,
   input logic RSTn,
   mem_port_arbiter_if.slave bus
);
   localparam int BW = beat_w(LINE_WORDS);
`ifdef MEM_ARB_CRIT_WORD_FIRST_EN
   localparam int START_MASK = 3;
`else
   localparam int START_MASK = 4 * LINE_WORDS - 1;
`endif
   state_t state, state_nx;
   logic idle_ok, i_gnt, d_gnt, accept, we_in, owner, last_gnt, beat_last, issue, fin;
   logic pv, plast, csn, wen;
   logic rv_i, rv_d, done_i, done_d;
   logic [BW-1:0] cnt, pbeat, rbeat_q;
   logic [BW:0] pipe_out;
   logic [ADDR_W-1:0] addr_in, start_addr, addr_q;
   logic [DATA_W-1:0] dout_q, rdata_q;
   logic [3:0] be_q, mem_be;
   assign idle_ok = RSTn && state == IDLE;
   assign i_gnt = idle_ok && bus.I_REQ && (!bus.D_REQ || last_gnt == REQ_D);
   assign d_gnt = idle_ok && bus.D_REQ && (!bus.I_REQ || last_gnt == REQ_I);
   assign accept = i_gnt || d_gnt;
   assign we_in = d_gnt ? bus.D_WE : bus.I_WE;
   assign addr_in = d_gnt ? bus.D_ADDR : bus.I_ADDR;
   assign start_addr = we_in ? addr_in & ~ADDR_W'(3) : addr_in & ~ADDR_W'(START_MASK);
   assign beat_last = cnt == BW'(LINE_WORDS - 1);
   assign issue = state == RD_ISSUE;
   assign fin = state == WR || (pv && plast);
   always_comb begin
      state_nx = state;
      csn = 1'b1;
      wen = 1'b1;
      mem_be = 4'h0;
      case (state)
         IDLE:     state_nx = accept ? (we_in ? WR : RD_ISSUE) : IDLE;
         RD_ISSUE: begin
            csn = 1'b0;
            state_nx = !beat_last ? RD_ISSUE : (MEM_LAT > 0 ? RD_DRAIN : IDLE);
         end
         RD_DRAIN: state_nx = pv && plast ? IDLE : RD_DRAIN;
         default: begin
            csn = 1'b0;
            wen = 1'b0;
            mem_be = be_q;
            state_nx = IDLE;
         end
      endcase
   end
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state <= IDLE;
         last_gnt <= REQ_I;
         owner <= REQ_I;
         cnt <= '0;
         addr_q <= '0;
         dout_q <= '0;
         be_q <= '0;
         rdata_q <= '0;
         rbeat_q <= '0;
         rv_i <= 1'b0;
         rv_d <= 1'b0;
         done_i <= 1'b0;
         done_d <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            owner <= d_gnt;
            last_gnt <= d_gnt;
            cnt <= '0;
            addr_q <= start_addr;
            be_q <= d_gnt ? bus.D_BE : bus.I_BE;
            if (we_in) dout_q <= d_gnt ? bus.D_WDATA : bus.I_WDATA;
         end else if (issue && !beat_last) begin
            cnt <= cnt + 1'b1;
            addr_q[BW+1:2] <= addr_q[BW+1:2] + 1'b1;
         end
         if (pv) begin
            rdata_q <= bus.D_MEM_DI;
            rbeat_q <= pbeat;
         end
         rv_i <= pv && owner == REQ_I;
         rv_d <= pv && owner == REQ_D;
         done_i <= fin && owner == REQ_I;
         done_d <= fin && owner == REQ_D;
      end
   end
   // Payload carries the word index plus a last-beat flag so DONE lines up with the final RVALID.
   mem_lat_pipe #(.LAT(MEM_LAT), .W(BW + 1)) u_pipe (
      .CLK(CLK),
      .RSTn(RSTn),
      .in_v(issue),
      .in_d({beat_last, addr_q[BW+1:2]}),
      .out_v(pv),
      .out_d(pipe_out)
   );
   assign plast = pipe_out[BW];
   assign pbeat = pipe_out[BW-1:0];
   assign bus.I_GNT = i_gnt;
   assign bus.D_GNT = d_gnt;
   assign bus.I_RVALID = rv_i;
   assign bus.D_RVALID = rv_d;
   assign bus.I_DONE = done_i;
   assign bus.D_DONE = done_d;
   assign bus.RDATA = rdata_q;
   assign bus.RBEAT = rbeat_q;
   assign bus.D_MEM_CSN = csn;
   assign bus.D_MEM_WEN = wen;
   assign bus.D_MEM_BE = mem_be;
   assign bus.D_MEM_ADDR = addr_q;
   assign bus.D_MEM_DOUT = dout_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single data-memory port (D_MEM_*) between two requesters: the instruction-side cache (I) and the data-side cache (D).
- Read requests are line refills: a LINE_WORDS-beat burst, one address per cycle, pipelined against memory read latency.
- Write requests are single-word write-through stores.
- Round-robin arbitration, one transaction in flight, no starvation.

Parameters:
ADDR_W, 12, byte-address width of memory and requester addresses
DATA_W, 32, word width
LINE_WORDS, 4, beats per read burst (power of 2, >=2)
MEM_LAT, 0, cycles from D_MEM_ADDR presented to D_MEM_DI valid (0..3; 0 = combinational read)

Ports:
CLK  in  1  clock, all state changes on rising edge
RSTn  in  1  synchronous active-low reset, sampled on CLK rising edge
I_REQ, D_REQ  in  1  request; held until accepted
I_WE, D_WE  in  1  1 = single-word write, 0 = line read
I_ADDR, D_ADDR  in  ADDR_W  byte address; bits [1:0] ignored
I_WDATA, D_WDATA  in  DATA_W  write data
I_BE, D_BE  in  4  write byte enables
I_GNT, D_GNT  out  1  accept; transfer occurs on the edge where REQ&GNT
I_RVALID, D_RVALID  out  1  read beat valid
RDATA  out  DATA_W  read beat data (shared; qualified by the *_RVALID)
RBEAT  out  log2(LINE_WORDS)  word index of the current beat within the line
I_DONE, D_DONE  out  1  one-cycle pulse, transaction complete
D_MEM_CSN  out  1  memory chip select, active low
D_MEM_WEN  out  1  memory write enable, active low
D_MEM_BE  out  4  memory byte enables
D_MEM_ADDR  out  ADDR_W  memory byte address, word aligned
D_MEM_DOUT  out  DATA_W  memory write data
D_MEM_DI  in  DATA_W  memory read data

Behaviour:
- States: IDLE, RD_ISSUE, RD_DRAIN, WR.
- GNT is combinational: asserted only in IDLE, only to the arbitration winner, and forced 0 while RSTn=0.
  - Single requester: that requester wins.
  - Both requesting: the requester not granted last wins.
  - Pointer resets to "I last", so D wins the first tie.
- On the accept edge, latch requester id, WE, ADDR, WDATA and BE.
  - WE=0: go to RD_ISSUE, beat counter = 0.
  - WE=1: go to WR.
- RD_ISSUE, one cycle per beat n = 0..LINE_WORDS-1:
  - D_MEM_CSN=0, D_MEM_WEN=1.
  - D_MEM_ADDR = {line base, word n, 2'b00}.
  - After the last beat: RD_DRAIN if MEM_LAT>0, otherwise IDLE.
- Read data path: a MEM_LAT-deep valid/beat-index shift register tracks addresses in flight.
  - Data for the address issued in cycle c is sampled at the end of cycle c+MEM_LAT.
  - RDATA/RBEAT/RVALID of the owner are registered, high in cycle c+MEM_LAT+1.
  - The owner's DONE pulses coincident with the last RVALID.
- RD_DRAIN: D_MEM_CSN=1; returns to IDLE the cycle the last beat is sampled.
- Read latency from accept edge (cycle 0): first RVALID at cycle 2+MEM_LAT, DONE at cycle LINE_WORDS+1+MEM_LAT.
- WR, one cycle:
  - D_MEM_CSN=0, D_MEM_WEN=0, D_MEM_ADDR=word-aligned ADDR, D_MEM_DOUT=WDATA, D_MEM_BE=BE.
  - Next state IDLE; owner's DONE pulses the following cycle (cycle 2).
- A new grant may be issued in the same cycle a DONE pulses, since the FSM is already in IDLE.
- Outside RD_ISSUE and WR, memory outputs are inactive: CSN=1, WEN=1, BE=0, ADDR/DOUT hold their last value.
- Reset values: all GNT/RVALID/DONE 0; RDATA 0; RBEAT 0; D_MEM_CSN 1; D_MEM_WEN 1; D_MEM_BE 0; D_MEM_ADDR 0; D_MEM_DOUT 0; state IDLE; pointer "I last"; shift register cleared.
- Reset mid-transaction: all of the above apply on the next edge. In-flight beats are discarded; no RVALID or DONE is issued for the aborted transaction.
- REQ deasserted before accept: the request is withdrawn, no side effects.

Optional Feature:
MEM_ARB_CRIT_WORD_FIRST_EN
- Defined: read bursts start at the requested word and wrap, beat n word = (ADDR[3:2]+n) mod LINE_WORDS. RBEAT reports the actual word index.
- Undefined: bursts always start at word 0 and RBEAT = n.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/RD_ISSUE/RD_DRAIN/WR)
  - requester id constants (REQ_I=0, REQ_D=1)
  - beat-index width function clog2(LINE_WORDS)
  - default ADDR_W/DATA_W
- One natural sub-module: mem_lat_pipe, the MEM_LAT-deep valid/beat shift register (pass-through when MEM_LAT=0).

Test Plan:
1. MEM_LAT=0, I read 0x124, no CWF -> D_MEM_ADDR 0x120,0x124,0x128,0x12C in cycles 1-4; I_RVALID cycles 2-5 with RBEAT 0-3; I_DONE cycle 5. With CWF -> 0x124,0x128,0x12C,0x120, RBEAT 1,2,3,0.
2. Right after reset, I and D read simultaneously -> D_GNT first; I_GNT the cycle D_DONE pulses. Repeated contention alternates I, D, I.
3. D write 0x040, WDATA 0xDEADBEEF, BE 4'b0011 -> in cycle 1 exactly: WEN=0, CSN=0, ADDR=0x040, DOUT=0xDEADBEEF, BE=0011; D_DONE cycle 2; no RVALID.
4. MEM_LAT=2, D read 0x300 -> addresses cycles 1-4; D_RVALID cycles 4-7; D_DONE cycle 7; CSN=1 cycles 5-7.
5. RSTn low during cycle 3 of an I burst -> next cycle CSN=1, all outputs at reset values; no further I_RVALID/I_DONE. After release, a new D request is granted immediately.
6. D_REQ held continuously while I_REQ is pending -> I granted no later than after one D transaction; I never starved.
